// File: rtl/mem_pkg.sv
// Shared definitions for mem_access_unit: RV32 load/store size codes, FSM states,
// and byte-lane / store-data helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  function automatic logic [3:0] gen_sel(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   gen_sel = 4'b0001 << a;
      2'b01:   gen_sel = 4'b0011 << a;
      default: gen_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] align_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   align_wdata = {4{wdata[7:0]}};
      2'b01:   align_wdata = {2{wdata[15:0]}};
      default: align_wdata = wdata;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) is_legal = f3 inside {F3_B, F3_H, F3_W};
    else    is_legal = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    is_misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Wishbone B4 classic bus bundle between mem_access_unit (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [3:0]            wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Shifts the addressed bytes of a read word down to bit 0 and sign/zero-extends them.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] wb_dat_i,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);
  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    shifted = wb_dat_i >> {addr, 3'b000};
    sext    = ~funct3[2];
    case (funct3[1:0])
      2'b00:   load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit running one request as a single Wishbone classic cycle.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  mem_access_unit_if.master     wb
);
  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            a_q, a_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] load_val;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
  end
`endif

  load_align u_load_align (
    .wb_dat_i (wb.wb_dat_i),
    .addr     (a_q),
    .funct3   (f3_q),
    .load_data(load_val)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    f3_d    = f3_q;
    a_d     = a_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        we_d  = req_we;
        f3_d  = req_funct3;
        a_d   = req_addr[1:0];
        adr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        sel_d = gen_sel(req_funct3, req_addr[1:0]);
        dat_d = align_wdata(req_funct3, req_wdata);
        if (!is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0])) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = BUS;
          cyc_d   = 1'b1;
          err_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        // An ack on the final watchdog cycle still completes the access normally.
        if (wb.wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = load_val;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          cyc_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      a_q     <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_dat_o = dat_q;
endmodule
